// File: rtl/upg_pkg.sv
// Shared types and helpers for the UART boot-image loader.
package upg_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE
    } upg_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Baud-tick divisor rounded to nearest: round(clk_hz / (16 * baud)).
    function automatic int unsigned upg_divisor(input int unsigned clk_hz,
                                                input int unsigned baud);
        return (clk_hz + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
    endfunction

endpackage

// File: rtl/upg_loader_uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, 16x oversampling tick, mid-bit sampling.
module uart_rx_core
    import upg_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_ferr_o
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);
    localparam logic [3:0] OS_BIT  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] OS_HALF = 4'(OVERSAMPLE / 2 - 1);

    logic [1:0]       sync_q;
    logic             prev_q;
    rx_state_e        state_q;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       os_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;

    logic rx_s;
    logic tick;
    logic mid;

    assign rx_s = sync_q[1];
    assign tick = (div_q == '0);
    assign mid  = tick && (os_q == 4'd0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q     <= 2'b11;
            prev_q     <= 1'b1;
            state_q    <= RX_IDLE;
            div_q      <= DIV_LOAD;
            os_q       <= 4'd0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            rx_data_o  <= 8'd0;
            rx_valid_o <= 1'b0;
            rx_ferr_o  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rx_i};
            prev_q     <= rx_s;
            rx_valid_o <= 1'b0;
            rx_ferr_o  <= 1'b0;
            div_q      <= tick ? DIV_LOAD : div_q - 1'b1;
            if (tick && state_q != RX_IDLE) begin
                os_q <= (os_q == 4'd0) ? OS_BIT : os_q - 1'b1;
            end
            case (state_q)
                // Falling edge only, so a line stuck low after a bad stop bit cannot re-trigger.
                RX_IDLE: if (prev_q && !rx_s) begin
                    state_q <= RX_START;
                    div_q   <= DIV_LOAD;
                    os_q    <= OS_HALF;
                end
                RX_START: if (mid) begin
                    state_q <= rx_s ? RX_IDLE : RX_DATA;
                    bit_q   <= 3'd0;
                end
                RX_DATA: if (mid) begin
                    shift_q <= {rx_s, shift_q[7:1]};
                    bit_q   <= bit_q + 1'b1;
                    if (bit_q == 3'd7) state_q <= RX_STOP;
                end
                RX_STOP: if (mid) begin
                    if (rx_s) begin
                        rx_data_o  <= shift_q;
                        rx_valid_o <= 1'b1;
                    end else begin
                        rx_ferr_o <= 1'b1;
                    end
                    state_q <= RX_IDLE;
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/upg_loader.sv
// UART boot-image loader: length-prefixed frame of little-endian words -> upg_* RAM write port.
// Optional trailing XOR checksum byte is enabled by defining UPG_CHECKSUM_EN.
module upg_loader
    import upg_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 10_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned ADR_W       = 14,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic             upg_clk_i,
    input  logic             upg_rstn_i,
    input  logic             uart_rx_i,
    output logic             upg_wen_o,
    output logic [ADR_W-1:0] upg_adr_o,
    output logic [31:0]      upg_dat_o,
    output logic             upg_done_o,
    output logic             upg_err_o
);

    localparam int unsigned DIV   = upg_divisor(CLK_HZ, BAUD);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx_core #(.DIV(DIV)) u_rx (
        .clk_i      (upg_clk_i),
        .rstn_i     (upg_rstn_i),
        .rx_i       (uart_rx_i),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_ferr_o  (rx_ferr)
    );

    upg_state_e       state_q;
    logic [ADR_W-1:0] cnt_q;
    logic [ADR_W-1:0] adr_q;
    logic [15:0]      len_q;
    logic [15:0]      words_q;
    logic [1:0]       idx_q;
    logic [23:0]      buf_q;
    logic [31:0]      dat_q;
    logic [TMO_W-1:0] tmo_q;
    logic             wen_q;
    logic             done_q;
    logic             err_q;
`ifdef UPG_CHECKSUM_EN
    logic [7:0]       chk_q;
`endif

    logic timed;
    logic timeout;
    logic abort;

    assign timed   = (state_q == S_LEN_HI) || (state_q == S_DATA) || (state_q == S_CHK);
    assign timeout = timed && (tmo_q == '0) && !rx_valid;
    assign abort   = (rx_ferr || timeout) && (state_q != S_DONE);

    always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
        if (!upg_rstn_i) begin
            state_q <= S_LEN_LO;
            cnt_q   <= '0;
            adr_q   <= '0;
            len_q   <= 16'd0;
            words_q <= 16'd0;
            idx_q   <= 2'd0;
            buf_q   <= 24'd0;
            dat_q   <= 32'd0;
            tmo_q   <= TMO_LOAD;
            wen_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef UPG_CHECKSUM_EN
            chk_q   <= 8'd0;
`endif
        end else begin
            wen_q <= 1'b0;
            // Timer restarts on every completed byte and whenever no frame is in flight.
            if (rx_valid || !timed) tmo_q <= TMO_LOAD;
            else                    tmo_q <= tmo_q - 1'b1;

            if (abort) begin
                err_q   <= 1'b1;
                state_q <= S_LEN_LO;
                cnt_q   <= '0;
                idx_q   <= 2'd0;
            end else begin
                case (state_q)
                    S_LEN_LO: if (rx_valid) begin
                        len_q[7:0] <= rx_data;
                        state_q    <= S_LEN_HI;
                    end
                    S_LEN_HI: if (rx_valid) begin
                        len_q[15:8] <= rx_data;
                        words_q     <= 16'd0;
                        idx_q       <= 2'd0;
`ifdef UPG_CHECKSUM_EN
                        chk_q       <= 8'd0;
`endif
                        if ({rx_data, len_q[7:0]} == 16'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: if (rx_valid) begin
`ifdef UPG_CHECKSUM_EN
                        chk_q <= chk_q ^ rx_data;
`endif
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == 2'd3) begin
                            dat_q   <= {rx_data, buf_q};
                            adr_q   <= cnt_q;
                            wen_q   <= 1'b1;
                            state_q <= S_WRITE;
                        end else begin
                            buf_q <= {rx_data, buf_q[23:8]};
                        end
                    end
                    S_WRITE: begin
                        cnt_q   <= cnt_q + 1'b1;
                        words_q <= words_q + 16'd1;
                        if (words_q + 16'd1 == len_q) begin
`ifdef UPG_CHECKSUM_EN
                            state_q <= S_CHK;
`else
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
`ifdef UPG_CHECKSUM_EN
                    S_CHK: if (rx_valid) begin
                        if (rx_data == chk_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_LEN_LO;
                            cnt_q   <= '0;
                        end
                    end
`endif
                    S_DONE: ;
                    default: state_q <= S_LEN_LO;
                endcase
            end
        end
    end

    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = done_q;
    assign upg_err_o  = err_q;

endmodule

// File: tb/tb_upg_loader.sv
// Bench for upg_loader: bit-banged UART frames, a frame-level reference model and a per-cycle write checker.
module tb_upg_loader;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 10_000;
    localparam int ADR_W  = 14;
    localparam int TMO    = 5000;
    localparam int BITC   = 160;

    logic             clk  = 1'b0;
    logic             rstn = 1'b0;
    logic             rx   = 1'b1;
    logic             wen;
    logic [ADR_W-1:0] adr;
    logic [31:0]      dat;
    logic             done;
    logic             err;

    always #5 clk = ~clk;

    upg_loader #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .ADR_W       (ADR_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .upg_clk_i  (clk),
        .upg_rstn_i (rstn),
        .uart_rx_i  (rx),
        .upg_wen_o  (wen),
        .upg_adr_o  (adr),
        .upg_dat_o  (dat),
        .upg_done_o (done),
        .upg_err_o  (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Frame-level reference model
    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [31:0]      dat;
    } wr_t;

    wr_t        exp_q[$];
    int         m_phase;   // 0 len lo, 1 len hi, 2 data, 3 checksum, 4 done
    int         m_len;
    int         m_words;
    int         m_adr;
    logic [7:0] m_bytes[$];
    logic [7:0] m_xor;
    bit         exp_done;
    bit         exp_err;

    task automatic model_reset();
        exp_q.delete();
        m_bytes.delete();
        m_phase = 0; m_len = 0; m_words = 0; m_adr = 0; m_xor = 8'h00;
        exp_done = 0; exp_err = 0;
    endtask

    task automatic model_abort();
        exp_err = 1;
        m_phase = 0;
        m_adr   = 0;
        m_bytes.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        wr_t w;
        case (m_phase)
            0: begin m_len = int'(b); m_phase = 1; end
            1: begin
                m_len   = m_len + 256 * int'(b);
                m_words = 0; m_xor = 8'h00;
                m_bytes.delete();
                if (m_len == 0) begin m_phase = 4; exp_done = 1; end
                else m_phase = 2;
            end
            2: begin
                m_bytes.push_back(b);
                m_xor = m_xor ^ b;
                if (m_bytes.size() == 4) begin
                    w.adr = ADR_W'(m_adr);
                    w.dat = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    exp_q.push_back(w);
                    m_adr = (m_adr + 1) % (1 << ADR_W);
                    m_words++;
                    m_bytes.delete();
                    if (m_words == m_len) begin
`ifdef UPG_CHECKSUM_EN
                        m_phase = 3;
`else
                        m_phase = 4; exp_done = 1;
`endif
                    end
                end
            end
            3: begin
                if (b == m_xor) begin m_phase = 4; exp_done = 1; end
                else model_abort();
            end
            default: ;
        endcase
    endtask

    task automatic model_timeout();
        if (m_phase >= 1 && m_phase <= 3) model_abort();
    endtask

    // Per-cycle checker: write stream, pulse width, held outputs, sticky flags
    longint           cyc = 0;
    longint           last_wen_cyc = -10;
    int               wen_count = 0;
    bit               prev_wen = 0, prev_done = 0, prev_err = 0;
    logic [ADR_W-1:0] held_adr = '0;
    logic [31:0]      held_dat = '0;

    always @(negedge clk) begin
        wr_t w;
        cyc++;
        if (!rstn) begin
            held_adr = '0; held_dat = '0;
            prev_wen = 0; prev_done = 0; prev_err = 0;
        end else begin
            if (wen) begin
                wen_count++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_wen: got wen at adr %h dat %h, expected no write", adr, dat);
                    held_adr = adr; held_dat = dat;
                end else begin
                    w = exp_q.pop_front();
                    check("wr_adr", 32'(adr), 32'(w.adr));
                    check("wr_dat", dat, w.dat);
                    held_adr = w.adr; held_dat = w.dat;
                end
                check("wen_width", 32'(prev_wen), 32'd0);
                check("done_with_wen", 32'(done), 32'd0);
                last_wen_cyc = cyc;
            end else begin
                check("adr_held", 32'(adr), 32'(held_adr));
                check("dat_held", dat, held_dat);
            end
            if (prev_done) check("done_sticky", 32'(done), 32'd1);
            if (prev_err)  check("err_sticky", 32'(err), 32'd1);
`ifndef UPG_CHECKSUM_EN
            if (done && !prev_done && m_len != 0)
                check("done_after_last_wen", 32'(cyc - last_wen_cyc), 32'd1);
`endif
            prev_wen = wen; prev_done = done; prev_err = err;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        rx = 1'b0;
        idle(BITC);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(BITC);
        end
        if (stop_ok) model_byte(b);
        else if (m_phase != 4) model_abort();
        rx = stop_ok;
        idle(BITC);
        rx = 1'b1;
        idle(4);
    endtask

    task automatic send_frame(input int n, input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] w;
        logic [7:0]  x;
        x = 8'h00;
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        for (int k = 0; k < n; k++) begin
            w = (k == 0) ? w0 : w1;
            for (int j = 0; j < 4; j++) begin
                send_byte(w[8*j +: 8]);
                x = x ^ w[8*j +: 8];
            end
        end
`ifdef UPG_CHECKSUM_EN
        if (n != 0) send_byte(x);
`endif
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle(3);
        model_reset();
        rstn = 1'b1;
        idle(2);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    int wc0;

    initial begin
        model_reset();
        rstn = 1'b0;
        rx   = 1'b1;
        idle(4);
        check("rst_wen", 32'(wen), 32'd0);
        check("rst_adr", 32'(adr), 32'd0);
        check("rst_dat", dat, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rstn = 1'b1;
        idle(4);

        // Two-word image
        wc0 = wen_count;
        send_frame(2, 32'h12345678, 32'hDEADBEEF);
        idle(20);
        check_quiet("t1");
        check("t1_adr", 32'(adr), 32'd1);
        check("t1_dat", dat, 32'hDEADBEEF);
        check("t1_done", 32'(done), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        check("t1_wen_count", 32'(wen_count - wc0), 32'd2);

        // Empty image, then a stray byte after DONE
        do_reset();
        wc0 = wen_count;
        send_frame(0, 32'h0, 32'h0);
        idle(20);
        check("t2_done", 32'(done), 32'd1);
        send_byte(8'h55);
        idle(20);
        check_quiet("t2");
        check("t2_done_after_stray", 32'(done), 32'd1);
        check("t2_err", 32'(err), 32'd0);
        check("t2_adr", 32'(adr), 32'd0);
        check("t2_dat", dat, 32'd0);
        check("t2_wen_count", 32'(wen_count - wc0), 32'd0);

        // Timeout mid-word, then recovery
        do_reset();
        wc0 = wen_count;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
        idle(4800);
        check("t3_err_before_timeout", 32'(err), 32'd0);
        model_timeout();
        idle(400);
        check("t3_err_after_timeout", 32'(err), 32'd1);
        check("t3_wen_count", 32'(wen_count - wc0), 32'd0);
        check_quiet("t3a");
        send_frame(1, 32'h44332211, 32'h0);
        idle(20);
        check_quiet("t3b");
        check("t3_adr", 32'(adr), 32'd0);
        check("t3_dat", dat, 32'h44332211);
        check("t3_done", 32'(done), 32'd1);

        // Framing error during DATA, then a glitch shorter than half a bit
        do_reset();
        wc0 = wen_count;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
        send_byte(8'hCC, 1'b0);
        idle(20);
        check("t4_err", 32'(err), 32'd1);
        check("t4_done", 32'(done), 32'd0);
        rx = 1'b0;
        #250;
        rx = 1'b1;
        idle(2000);
        check_quiet("t4a");
        send_frame(1, 32'h04030201, 32'h0);
        idle(20);
        check_quiet("t4b");
        check("t4_adr", 32'(adr), 32'd0);
        check("t4_dat", dat, 32'h04030201);
        check("t4_wen_count", 32'(wen_count - wc0), 32'd1);

        // Reset in the middle of the second word
        do_reset();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h67); send_byte(8'h45); send_byte(8'h23); send_byte(8'h01);
        send_byte(8'hA1); send_byte(8'hB2);
        check("t5_pre_dat", dat, 32'h01234567);
        rstn = 1'b0;
        idle(3);
        check("t5_rst_wen", 32'(wen), 32'd0);
        check("t5_rst_adr", 32'(adr), 32'd0);
        check("t5_rst_dat", dat, 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_err", 32'(err), 32'd0);
        model_reset();
        rstn = 1'b1;
        idle(2);
        send_frame(1, 32'hAABBCCDD, 32'h0);
        idle(20);
        check_quiet("t5");
        check("t5_adr", 32'(adr), 32'd0);
        check("t5_dat", dat, 32'hAABBCCDD);
        check("t5_done", 32'(done), 32'd1);

`ifdef UPG_CHECKSUM_EN
        do_reset();
        foreach (send_good[i]) send_byte(send_good[i]);
        idle(20);
        check_quiet("t6a");
        check("t6_good_done", 32'(done), 32'd1);
        check("t6_good_err", 32'(err), 32'd0);
        check("t6_good_dat", dat, 32'h44332211);
        do_reset();
        wc0 = wen_count;
        foreach (send_bad[i]) send_byte(send_bad[i]);
        idle(20);
        check_quiet("t6b");
        check("t6_bad_wen_count", 32'(wen_count - wc0), 32'd1);
        check("t6_bad_err", 32'(err), 32'd1);
        check("t6_bad_done", 32'(done), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

`ifdef UPG_CHECKSUM_EN
    logic [7:0] send_good[7] = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    logic [7:0] send_bad[7]  = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
`endif

endmodule
